// File: rtl/qs_srt_stack.sv
// rtl/qs_srt_stack.sv - parametrised LIFO for push/pop and call/ret with bypass, flush and sticky errors
module qs_srt_stack #(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 push,
  input  logic [W-1:0]         push_dat,
  input  logic                 pop,
  output logic                 pop_dat_vld,
  output logic [W-1:0]         pop_dat,
  output logic [W-1:0]         top,
  output logic [$clog2(N):0]   cnt,
  output logic                 empty,
  output logic                 full,
  output logic                 err_ovf,
  output logic                 err_udf
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  logic [W-1:0]  mem_q [N];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  pop_dat_q, pop_dat_d;
  logic          pop_dat_vld_q, pop_dat_vld_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_udf_q, err_udf_d;

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [CW-1:0] cnt_m1;
  logic [AW-1:0] top_idx;
  logic [W-1:0]  top_ent;
  logic          is_empty;
  logic          is_full;

  assign cnt_m1   = cnt_q - CNT_ONE;
  assign top_idx  = cnt_m1[AW-1:0];
  assign top_ent  = mem_q[top_idx];
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_MAX);

  // Next-state for occupancy, pop register and error flags; also picks the single memory write.
  always_comb begin
    cnt_d         = cnt_q;
    pop_dat_d     = pop_dat_q;
    pop_dat_vld_d = 1'b0;
    err_ovf_d     = err_ovf_q;
    err_udf_d     = err_udf_q;
    mem_we        = 1'b0;
    mem_wa        = cnt_q[AW-1:0];
    if (clr) begin
      cnt_d     = '0;
      err_ovf_d = 1'b0;
      err_udf_d = 1'b0;
    end else if (push && pop) begin
      // Replace-top: occupancy unchanged; an empty stack bypasses push data straight out.
      pop_dat_vld_d = 1'b1;
      if (is_empty) begin
        pop_dat_d = push_dat;
      end else begin
        pop_dat_d = top_ent;
        mem_we    = 1'b1;
        mem_wa    = top_idx;
      end
    end else if (push) begin
      if (is_full) begin
        err_ovf_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + CNT_ONE;
      end
    end else if (pop) begin
      if (is_empty) begin
        err_udf_d = 1'b1;
      end else begin
        pop_dat_d     = top_ent;
        pop_dat_vld_d = 1'b1;
        cnt_d         = cnt_m1;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      pop_dat_q     <= '0;
      pop_dat_vld_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_udf_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pop_dat_q     <= pop_dat_d;
      pop_dat_vld_q <= pop_dat_vld_d;
      err_ovf_q     <= err_ovf_d;
      err_udf_q     <= err_udf_d;
    end
  end

  // Storage array is left unreset; writes are suppressed while reset or flush is active.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_wa] <= push_dat;
    end
  end

  assign pop_dat_vld = pop_dat_vld_q;
  assign pop_dat     = pop_dat_q;
  assign top         = is_empty ? '0 : top_ent;
  assign cnt         = cnt_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign err_ovf     = err_ovf_q;
  assign err_udf     = err_udf_q;

endmodule

// File: tb/tb_qs_srt_stack.sv
// tb/tb_qs_srt_stack.sv - self-checking bench for qs_srt_stack (N=8, N=2 and N=16 instances)
module tb_qs_srt_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] push_dat = 16'h0;

  logic [15:0] o_top [3];
  logic [15:0] o_pd  [3];
  logic [4:0]  o_cnt [3];
  logic        o_vld [3];
  logic        o_emp [3];
  logic        o_full[3];
  logic        o_ovf [3];
  logic        o_udf [3];

  logic [3:0]  c0;
  logic [1:0]  c1;
  logic [4:0]  c2;
  logic [7:0]  pd1, top1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qs_srt_stack #(.W(16), .N(8)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .push_dat(push_dat), .pop(pop),
    .pop_dat_vld(o_vld[0]), .pop_dat(o_pd[0]), .top(o_top[0]), .cnt(c0),
    .empty(o_emp[0]), .full(o_full[0]), .err_ovf(o_ovf[0]), .err_udf(o_udf[0]));

  qs_srt_stack #(.W(8), .N(2)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .push_dat(push_dat[7:0]), .pop(pop),
    .pop_dat_vld(o_vld[1]), .pop_dat(pd1), .top(top1), .cnt(c1),
    .empty(o_emp[1]), .full(o_full[1]), .err_ovf(o_ovf[1]), .err_udf(o_udf[1]));

  qs_srt_stack #(.W(16), .N(16)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .push_dat(push_dat), .pop(pop),
    .pop_dat_vld(o_vld[2]), .pop_dat(o_pd[2]), .top(o_top[2]), .cnt(c2),
    .empty(o_emp[2]), .full(o_full[2]), .err_ovf(o_ovf[2]), .err_udf(o_udf[2]));

  assign o_cnt[0] = {1'b0, c0};
  assign o_cnt[1] = {3'b0, c1};
  assign o_cnt[2] = c2;
  assign o_pd[1]  = {8'h0, pd1};
  assign o_top[1] = {8'h0, top1};

  // Reference model state per instance
  int unsigned mq [3][$];
  int unsigned eq [3][$];
  int unsigned mpd [3];
  bit          mvld[3];
  bit          movf[3];
  bit          mudf[3];
  int          nd  [3] = '{8, 2, 16};
  int unsigned wm  [3] = '{32'hFFFF, 32'hFF, 32'hFFFF};

  typedef struct {
    bit          r, c, pu, po;
    logic [15:0] dat;
    int unsigned cnt;
    int unsigned top;
    bit          vld;
    int unsigned pd;
    bit          ovf, udf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit c, bit pu, bit po, logic [15:0] dat, int unsigned cnt,
                              int unsigned top, bit vld, int unsigned pd, bit ovf, bit udf);
    vec_t v;
    v.r = r; v.c = c; v.pu = pu; v.po = po; v.dat = dat; v.cnt = cnt; v.top = top;
    v.vld = vld; v.pd = pd; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_update(input int k, input bit r, input bit c, input bit pu, input bit po,
                              input logic [15:0] d);
    int unsigned v;
    v = int'(d) & wm[k];
    if (r) begin
      mq[k].delete(); eq[k].delete();
      movf[k] = 0; mudf[k] = 0; mvld[k] = 0; mpd[k] = 0;
    end else if (c) begin
      mq[k].delete();
      movf[k] = 0; mudf[k] = 0; mvld[k] = 0;
    end else if (pu && po) begin
      mvld[k] = 1;
      if (mq[k].size() == 0) mpd[k] = v;
      else begin
        mpd[k] = mq[k].pop_back();
        mq[k].push_back(v);
      end
      eq[k].push_back(mpd[k]);
    end else if (pu) begin
      mvld[k] = 0;
      if (mq[k].size() == nd[k]) movf[k] = 1;
      else mq[k].push_back(v);
    end else if (po) begin
      if (mq[k].size() == 0) begin
        mudf[k] = 1; mvld[k] = 0;
      end else begin
        mpd[k] = mq[k].pop_back(); mvld[k] = 1;
        eq[k].push_back(mpd[k]);
      end
    end else begin
      mvld[k] = 0;
    end
  endtask

  task automatic model_check(input int k);
    int unsigned etop;
    etop = (mq[k].size() == 0) ? 0 : mq[k][$];
    chk($sformatf("vld[%0d]", k), o_vld[k], mvld[k]);
    if (o_vld[k]) begin
      if (eq[k].size() == 0) begin
        tests++; fails++;
        $display("FAIL sb[%0d]: pop_dat_vld with nothing expected, got 0x%0h", k, o_pd[k]);
      end else begin
        chk($sformatf("sb_pop[%0d]", k), o_pd[k], eq[k].pop_front());
      end
    end else begin
      eq[k].delete();
    end
    chk($sformatf("pop_dat[%0d]", k), o_pd[k], mpd[k]);
    chk($sformatf("cnt[%0d]", k), o_cnt[k], mq[k].size());
    chk($sformatf("top[%0d]", k), o_top[k], etop);
    chk($sformatf("empty[%0d]", k), o_emp[k], mq[k].size() == 0);
    chk($sformatf("full[%0d]", k), o_full[k], mq[k].size() == nd[k]);
    chk($sformatf("ovf[%0d]", k), o_ovf[k], movf[k]);
    chk($sformatf("udf[%0d]", k), o_udf[k], mudf[k]);
  endtask

  task automatic step(input bit r, input bit c, input bit pu, input bit po, input logic [15:0] d);
    rst = r; clr = c; push = pu; pop = po; push_dat = d;
    for (int k = 0; k < 3; k++) model_update(k, r, c, pu, po, d);
    @(posedge clk);
    #1;
    rst = 0; clr = 0; push = 0; pop = 0;
    for (int k = 0; k < 3; k++) model_check(k);
  endtask

  initial begin
    // rst clr push pop dat | cnt top vld pop_dat ovf udf  (expected for N=8 instance)
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0011, 1, 16'h0011, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0022, 2, 16'h0022, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0033, 3, 16'h0033, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 2, 16'h0022, 1, 16'h0033, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 16'h0011, 1, 16'h0022, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0011, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'h0011, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0011, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 16'h1234, 0, 16'h0000, 1, 16'h1234, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h1234, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0001, 1, 16'h0001, 0, 16'h1234, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0002, 2, 16'h0002, 0, 16'h1234, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0003, 3, 16'h0003, 0, 16'h1234, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0004, 4, 16'h0004, 0, 16'h1234, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].pu, tbl[i].po, tbl[i].dat);
      chk($sformatf("v%0d.cnt", i), o_cnt[0], tbl[i].cnt);
      chk($sformatf("v%0d.top", i), o_top[0], tbl[i].top);
      chk($sformatf("v%0d.vld", i), o_vld[0], tbl[i].vld);
      chk($sformatf("v%0d.pd", i), o_pd[0], tbl[i].pd);
      chk($sformatf("v%0d.ovf", i), o_ovf[0], tbl[i].ovf);
      chk($sformatf("v%0d.udf", i), o_udf[0], tbl[i].udf);
    end

    // Fill to N=8, overflow, replace-top on full stack
    step(1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'(i));
    chk("fill.full", o_full[0], 1);
    chk("fill.cnt", o_cnt[0], 8);
    step(0, 0, 1, 0, 16'hBEEF);
    chk("ovf.flag", o_ovf[0], 1);
    chk("ovf.top", o_top[0], 16'h0007);
    chk("ovf.cnt", o_cnt[0], 8);
    step(0, 0, 1, 1, 16'h00AA);
    chk("rep.vld", o_vld[0], 1);
    chk("rep.pd", o_pd[0], 16'h0007);
    chk("rep.top", o_top[0], 16'h00AA);
    chk("rep.cnt", o_cnt[0], 8);

    // Pop down to 5 with overflow still latched, then flush with a concurrent push
    step(0, 0, 0, 1, 16'h0);
    chk("pop1.pd", o_pd[0], 16'h00AA);
    step(0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 1, 16'h0);
    chk("pop3.pd", o_pd[0], 16'h0005);
    chk("pre_clr.cnt", o_cnt[0], 5);
    chk("pre_clr.ovf", o_ovf[0], 1);
    step(0, 1, 1, 0, 16'h0099);
    chk("clr.cnt", o_cnt[0], 0);
    chk("clr.ovf", o_ovf[0], 0);
    chk("clr.vld", o_vld[0], 0);
    chk("clr.top", o_top[0], 0);
    chk("clr.empty", o_emp[0], 1);

    // Random mix against the queue model for all three instances
    for (int i = 0; i < 2000; i++) begin
      bit r, c, pu, po;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 99) == 0);
      if (((i / 250) % 2) == 0) pu = ($urandom_range(0, 99) < 70);
      else pu = ($urandom_range(0, 99) < 30);
      po = ($urandom_range(0, 99) < 45);
      step(r, c, pu, po, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
